gb_xact_checker: RTL and testbench

- Synthesisable ghostbus master that runs a self-checking transaction sweep over a table of N_ADDRS addresses.
- Sweep sequence: snapshot read, repeatability read, write, readback verify.
- Parametrised in address width, data width, table depth and read latency. Adds what the hand-rolled sweep lacks: per-entry compare mask, write-skip mode, inter-transaction gap, error counting and first-error capture.
- Sits beside the top-level bus decoder as a built-in self-test / bring-up engine, muxed onto the gb_* bus.

---
 rtl/gb_xact_pkg.sv | 17 +
 rtl/gb_xact_snap_ram.sv | 26 ++
 rtl/gb_xact_checker.sv | 205 ++++++++++++++++++++
 tb/tb_gb_xact_checker.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_xact_pkg.sv
// Shared encodings for the ghostbus transaction checker: sweep phases
// (also the err_phase output encoding) and FSM states.
package gb_xact_pkg;

  localparam logic [1:0] PH_SNAP   = 2'd0;
  localparam logic [1:0] PH_REPEAT = 2'd1;
  localparam logic [1:0] PH_WRITE  = 2'd2;
  localparam logic [1:0] PH_VERIFY = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/gb_xact_snap_ram.sv
// Snapshot store for the checker: one masked read value per table entry.
// Simple dual-port, registered read with one cycle of latency.
module gb_xact_snap_ram
  import gb_xact_pkg::*;
#(
  parameter int DW      = 32,
  parameter int N_ADDRS = 46,
  parameter int IDXW    = 6
) (
  input  logic            gb_clk,
  input  logic            we,
  input  logic [IDXW-1:0] waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [IDXW-1:0] raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [N_ADDRS];

  // Write port and registered read port; contents are not reset.
  always_ff @(posedge gb_clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/gb_xact_checker.sv
// Ghostbus self-test master: sweeps a table of addresses through
// snapshot read, repeat read, write and readback-verify passes, counting
// masked mismatches and capturing the first one.
module gb_xact_checker
  import gb_xact_pkg::*;
#(
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int N_ADDRS    = 46,
  parameter int IDXW       = 6,
  parameter int READ_DELAY = 3,
  parameter int GAP        = 2,
  parameter int ERRW       = 16
) (
  input  logic            gb_clk,
  input  logic            gb_rst,
  input  logic            start,
  input  logic            skip_write,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_cnt,
  output logic [IDXW-1:0] err_idx,
  output logic [1:0]      err_phase,
  output logic [DW-1:0]   err_got,
  output logic [IDXW-1:0] tbl_idx,
  input  logic [AW-1:0]   tbl_addr,
  input  logic [DW-1:0]   tbl_wval,
  input  logic [DW-1:0]   tbl_mask,
  output logic [AW-1:0]   gb_addr,
  output logic [DW-1:0]   gb_wdata,
  output logic            gb_wen,
  output logic            gb_rstb,
  input  logic [DW-1:0]   gb_rdata
);

  localparam int              CW       = $clog2(READ_DELAY + GAP + 2);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_ADDRS - 1);

  logic [2:0]      state;
  logic [1:0]      phase;
  logic [IDXW-1:0] idx;
  logic [CW-1:0]   cnt;
  logic            skip_q;
  logic            pass_q;
  logic [DW-1:0]   mask_q;
  logic [DW-1:0]   wval_q;
  logic [DW-1:0]   snap_rd;
  logic [DW-1:0]   rdata_m;
  logic            snap_we;
  logic            mismatch;
  logic [2:0]      adv_state;
  logic [1:0]      adv_phase;
  logic [IDXW-1:0] adv_idx;

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (&v) ? v : v + ERRW'(1);
  endfunction

  // Snapshot RAM: address is the live index, so read data is ready by CHECK.
  gb_xact_snap_ram #(
    .DW      (DW),
    .N_ADDRS (N_ADDRS),
    .IDXW    (IDXW)
  ) u_snap (
    .gb_clk (gb_clk),
    .we     (snap_we),
    .waddr  (idx),
    .wdata  (rdata_m),
    .raddr  (idx),
    .rdata  (snap_rd)
  );

  // Compare the bus data sampled at the end of CHECK against the reference.
  always_comb begin
    rdata_m  = gb_rdata & mask_q;
    snap_we  = (state == ST_CHECK) && (phase == PH_SNAP);
    mismatch = 1'b0;
    if (state == ST_CHECK) begin
      if (phase == PH_REPEAT) mismatch = (rdata_m != snap_rd);
      if (phase == PH_VERIFY) mismatch = (rdata_m != (wval_q & mask_q));
    end
  end

  // Where the sweep goes once a transaction (and its gap) is finished.
  always_comb begin
    adv_state = ST_ISSUE;
    adv_phase = phase;
    adv_idx   = idx + IDXW'(1);
    if (idx == LAST_IDX) begin
      adv_idx = '0;
      case (phase)
        PH_SNAP:   adv_phase = PH_REPEAT;
        PH_REPEAT: begin
          if (skip_q) adv_state = ST_DONE;
          else        adv_phase = PH_WRITE;
        end
        PH_WRITE:  adv_phase = PH_VERIFY;
        default:   adv_state = ST_DONE;
      endcase
    end
  end

  // Sweep FSM, bus strobes and error capture.
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      state     <= ST_IDLE;
      phase     <= PH_SNAP;
      idx       <= '0;
      cnt       <= '0;
      skip_q    <= 1'b0;
      pass_q    <= 1'b0;
      mask_q    <= '0;
      wval_q    <= '0;
      err_cnt   <= '0;
      err_idx   <= '0;
      err_phase <= '0;
      err_got   <= '0;
      gb_addr   <= '0;
      gb_wdata  <= '0;
      gb_wen    <= 1'b0;
      gb_rstb   <= 1'b0;
    end else begin
      gb_wen  <= 1'b0;
      gb_rstb <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_cnt   <= '0;
            err_idx   <= '0;
            err_phase <= '0;
            err_got   <= '0;
            pass_q    <= 1'b0;
            skip_q    <= skip_write;
            phase     <= PH_SNAP;
            idx       <= '0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          gb_addr <= tbl_addr;
          mask_q  <= tbl_mask;
          wval_q  <= tbl_wval;
          cnt     <= '0;
          if (phase == PH_WRITE) begin
            gb_wen   <= 1'b1;
            gb_wdata <= tbl_wval;
            if (GAP == 0) begin
              state <= adv_state;
              phase <= adv_phase;
              idx   <= adv_idx;
            end else begin
              state <= ST_GAP;
            end
          end else begin
            gb_rstb <= 1'b1;
            state   <= (READ_DELAY == 1) ? ST_CHECK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == CW'(READ_DELAY - 2)) state <= ST_CHECK;
          else                            cnt   <= cnt + CW'(1);
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_cnt <= sat_inc(err_cnt);
            if (err_cnt == '0) begin
              err_idx   <= idx;
              err_phase <= phase;
              err_got   <= gb_rdata;
            end
          end
          cnt <= '0;
          if (GAP == 0) begin
            state <= adv_state;
            phase <= adv_phase;
            idx   <= adv_idx;
          end else begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt == CW'(GAP - 1)) begin
            state <= adv_state;
            phase <= adv_phase;
            idx   <= adv_idx;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          pass_q <= (err_cnt == '0);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tbl_idx = idx;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign pass    = done ? (err_cnt == '0) : pass_q;

endmodule

// File: tb/tb_gb_xact_checker.sv
// Bench for gb_xact_checker: reg-file stub with injectable faults on the bus,
// reference model computing the expected sweep outcome from the logged reads.
module tb_gb_xact_checker;

  localparam int AW = 24, DW = 32, N = 4, IDXW = 2, RD = 3, GP = 2, ERRW = 3;

  logic            gb_clk = 1'b0;
  logic            gb_rst = 1'b1;
  logic            start = 1'b0;
  logic            skip_write = 1'b0;
  logic            busy, done, pass;
  logic [ERRW-1:0] err_cnt;
  logic [IDXW-1:0] err_idx, tbl_idx;
  logic [1:0]      err_phase;
  logic [DW-1:0]   err_got;
  logic [AW-1:0]   tbl_addr, gb_addr;
  logic [DW-1:0]   tbl_wval, tbl_mask, gb_wdata, gb_rdata;
  logic            gb_wen, gb_rstb;

  logic [AW-1:0] t_addr [N];
  logic [DW-1:0] t_wval [N];
  logic [DW-1:0] t_mask [N];

  int passed = 0;
  int total  = 0;

  always #5 gb_clk = ~gb_clk;

  assign tbl_addr = t_addr[tbl_idx];
  assign tbl_wval = t_wval[tbl_idx];
  assign tbl_mask = t_mask[tbl_idx];

  gb_xact_checker #(
    .AW(AW), .DW(DW), .N_ADDRS(N), .IDXW(IDXW),
    .READ_DELAY(RD), .GAP(GP), .ERRW(ERRW)
  ) dut (
    .gb_clk(gb_clk), .gb_rst(gb_rst), .start(start), .skip_write(skip_write),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .err_idx(err_idx), .err_phase(err_phase), .err_got(err_got),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_wval(tbl_wval),
    .tbl_mask(tbl_mask), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
    .gb_wen(gb_wen), .gb_rstb(gb_rstb), .gb_rdata(gb_rdata)
  );

  // ---------------- reg-file stub with fault modes ----------------
  logic [DW-1:0] mem [64];
  logic [DW-1:0] init_val [64];
  logic          stub_load = 1'b0;
  bit            m_toggle4 = 0, m_ignore5 = 0, m_garbage1 = 0, m_serial = 0, m_noise = 0;
  logic          tog4;
  int            serial;
  logic [DW-1:0] noise_q;
  logic          noise_hit_q;
  logic [4:0]    noise_bit_q;
  logic [DW-1:0] rd_val, rd_p0, rd_p1;
  logic [AW-1:0] rlog_a [$];
  logic [DW-1:0] rlog_d [$];
  logic [AW-1:0] wlog_a [$];
  logic [DW-1:0] wlog_d [$];

  always_comb begin
    rd_val = mem[gb_addr[5:0]];
    if (m_toggle4 && gb_addr == 24'd4) rd_val = rd_val ^ {31'b0, tog4};
    if (m_ignore5 && gb_addr == 24'd5) rd_val = '0;
    if (m_garbage1 && gb_addr == 24'd1) rd_val = rd_val | (noise_q & 32'hFFFF_FFF0);
    if (m_serial) rd_val = rd_val ^ DW'(serial);
    if (noise_hit_q) rd_val = rd_val ^ (32'h1 << noise_bit_q);
  end

  // Read data appears READ_DELAY cycles after the strobe edge; otherwise junk.
  always @(posedge gb_clk) begin
    noise_q     <= $urandom;
    noise_hit_q <= m_noise && ($urandom_range(0, 3) == 0);
    noise_bit_q <= 5'($urandom_range(0, 7));
    rd_p0       <= gb_rstb ? rd_val : 32'hDEAD_BEEF;
    rd_p1       <= rd_p0;
    if (stub_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val[i];
      tog4   <= 1'b0;
      serial <= 0;
    end else begin
      if (gb_rstb) begin
        rlog_a.push_back(gb_addr);
        rlog_d.push_back(rd_val);
        serial <= serial + 1;
        if (m_toggle4 && gb_addr == 24'd4) tog4 <= ~tog4;
      end
      if (gb_wen) begin
        wlog_a.push_back(gb_addr);
        wlog_d.push_back(gb_wdata);
        if (!(m_ignore5 && gb_addr == 24'd5)) mem[gb_addr[5:0]] <= gb_wdata;
      end
    end
  end
  assign gb_rdata = rd_p1;

  // ---------------- helpers (stimulus and model only) ----------------
  task automatic stub_init();
    for (int i = 0; i < 64; i++) init_val[i] = 32'h5A00_0000 | i;
    stub_load = 1'b1;
    @(negedge gb_clk);
    stub_load = 1'b0;
  endtask

  task automatic set_fixed_table();
    t_addr[0] = 24'd0; t_addr[1] = 24'd1; t_addr[2] = 24'd4; t_addr[3] = 24'd5;
    t_wval[0] = 32'hcc; t_wval[1] = 32'h01; t_wval[2] = 32'h04; t_wval[3] = 32'h05;
    t_mask[0] = 32'hff; t_mask[1] = 32'h0f; t_mask[2] = 32'h0f; t_mask[3] = 32'h0f;
  endtask

  task automatic clear_modes();
    m_toggle4 = 0; m_ignore5 = 0; m_garbage1 = 0; m_serial = 0; m_noise = 0;
  endtask

  function automatic int exp_busy(input bit skip);
    return (skip ? 2 : 3) * N * (1 + RD + GP) + (skip ? 0 : N * (1 + GP)) + 1;
  endfunction

  // Outcome of a sweep from the reads actually returned by the bus.
  task automatic model(input bit skip, output logic [ERRW-1:0] c,
                       output logic [IDXW-1:0] fi, output logic [1:0] fp,
                       output logic [DW-1:0] fg);
    logic [DW-1:0] snap [N];
    logic [DW-1:0] d;
    c = '0; fi = '0; fp = '0; fg = '0;
    for (int i = 0; i < N; i++)
      snap[i] = ((i < rlog_d.size()) ? rlog_d[i] : 32'hBAD0_BAD0) & t_mask[i];
    for (int p = 1; p <= (skip ? 1 : 2); p++) begin
      for (int i = 0; i < N; i++) begin
        d = ((p * N + i) < rlog_d.size()) ? rlog_d[p * N + i] : 32'hBAD0_BAD0;
        if ((d & t_mask[i]) != ((p == 1) ? snap[i] : (t_wval[i] & t_mask[i]))) begin
          if (c == '0) begin fi = IDXW'(i); fp = (p == 1) ? 2'd1 : 2'd3; fg = d; end
          if (c != '1) c = c + 1'b1;
        end
      end
    end
  endtask

  // Starts a sweep at the current negedge; returns on the negedge after done.
  task automatic run_sweep(input bit skip, input int stray_at, output int bcyc,
                           output int dcnt, output logic pass_at_done);
    bcyc = 0; dcnt = 0; pass_at_done = 1'b0;
    rlog_a.delete(); rlog_d.delete(); wlog_a.delete(); wlog_d.delete();
    start = 1'b1; skip_write = skip;
    @(negedge gb_clk);
    skip_write = ~skip;
    for (int c = 0; c < 1000; c++) begin
      start = (c == stray_at);
      if (busy) bcyc++;
      if (done) begin dcnt++; pass_at_done = pass; break; end
      @(negedge gb_clk);
    end
    start = 1'b0;
    @(negedge gb_clk);
    if (done) dcnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    gb_rst = 1'b1;
    repeat (3) @(negedge gb_clk);
    total++;
    if ({busy, done, pass, err_cnt, err_idx, err_phase, err_got, tbl_idx,
         gb_addr, gb_wdata, gb_wen, gb_rstb} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b cnt=%0d addr=%h wen=%b rstb=%b, want all 0",
               busy, done, pass, err_cnt, gb_addr, gb_wen, gb_rstb);
    else passed++;
    gb_rst = 1'b0;
    @(negedge gb_clk);
  endtask

  task automatic test_clean_sweep();
    int bcyc, dcnt; logic pd;
    logic [ERRW-1:0] ec; logic [IDXW-1:0] ei; logic [1:0] ep; logic [DW-1:0] eg;
    bit ok;
    clear_modes(); set_fixed_table(); stub_init();
    run_sweep(1'b0, -1, bcyc, dcnt, pd);
    model(1'b0, ec, ei, ep, eg);
    total++; if (dcnt !== 1) $display("FAIL clean_done_pulses: got %0d want 1", dcnt); else passed++;
    total++; if (bcyc !== exp_busy(0)) $display("FAIL clean_busy_cycles: got %0d want %0d", bcyc, exp_busy(0)); else passed++;
    total++; if (pd !== 1'b1 || pass !== 1'b1) $display("FAIL clean_pass: got %b/%b want 1/1", pd, pass); else passed++;
    total++; if (err_cnt !== 0 || ec !== 0) $display("FAIL clean_err_cnt: got %0d model %0d want 0", err_cnt, ec); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL clean_busy_after: got %b want 0", busy); else passed++;
    ok = (rlog_a.size() == 3 * N);
    for (int k = 0; k < rlog_a.size() && ok; k++) ok = (rlog_a[k] == t_addr[k % N]);
    total++; if (!ok) $display("FAIL clean_read_seq: got %0d reads want %0d in table order", rlog_a.size(), 3 * N); else passed++;
    ok = (wlog_a.size() == N);
    for (int k = 0; k < wlog_a.size() && ok; k++) ok = (wlog_a[k] == t_addr[k]) && (wlog_d[k] == t_wval[k]);
    total++; if (!ok) $display("FAIL clean_write_seq: got %0d writes want %0d matching table", wlog_a.size(), N); else passed++;
    ok = 1;
    for (int i = 0; i < N; i++) ok = ok && (mem[t_addr[i][5:0]] == t_wval[i]);
    total++; if (!ok) $display("FAIL clean_stub_contents: got %h want %h (entry 0)", mem[0], t_wval[0]); else passed++;
  endtask

  task automatic test_toggle_repeat();
    int bcyc, dcnt; logic pd;
    logic [ERRW-1:0] ec; logic [IDXW-1:0] ei; logic [1:0] ep; logic [DW-1:0] eg;
    clear_modes(); set_fixed_table(); stub_init(); m_toggle4 = 1;
    run_sweep(1'b0, -1, bcyc, dcnt, pd);
    model(1'b0, ec, ei, ep, eg);
    total++; if (err_cnt !== 1 || err_idx !== 2 || err_phase !== 1)
      $display("FAIL toggle_first_err: got cnt=%0d idx=%0d ph=%0d want 1/2/1", err_cnt, err_idx, err_phase); else passed++;
    total++; if (err_got !== eg) $display("FAIL toggle_err_got: got %h want %h", err_got, eg); else passed++;
    total++; if (pd !== 1'b0 || pass !== 1'b0 || dcnt !== 1) $display("FAIL toggle_pass: got pass=%b done=%0d want 0/1", pass, dcnt); else passed++;
  endtask

  task automatic test_verify_fail();
    int bcyc, dcnt; logic pd;
    clear_modes(); set_fixed_table(); stub_init(); m_ignore5 = 1;
    run_sweep(1'b0, -1, bcyc, dcnt, pd);
    total++; if (err_cnt !== 1 || err_idx !== 3 || err_phase !== 3 || err_got !== 0)
      $display("FAIL verify_first_err: got cnt=%0d idx=%0d ph=%0d got=%h want 1/3/3/0", err_cnt, err_idx, err_phase, err_got); else passed++;
    total++; if (pass !== 1'b0) $display("FAIL verify_pass: got %b want 0", pass); else passed++;
  endtask

  task automatic test_skip_write();
    int bcyc, dcnt; logic pd;
    clear_modes(); set_fixed_table(); stub_init();
    run_sweep(1'b1, -1, bcyc, dcnt, pd);
    total++; if (wlog_a.size() !== 0) $display("FAIL skip_writes: got %0d want 0", wlog_a.size()); else passed++;
    total++; if (rlog_a.size() !== 2 * N) $display("FAIL skip_reads: got %0d want %0d", rlog_a.size(), 2 * N); else passed++;
    total++; if (bcyc !== exp_busy(1) || dcnt !== 1) $display("FAIL skip_busy: got %0d/%0d want %0d/1", bcyc, dcnt, exp_busy(1)); else passed++;
    total++; if (pd !== 1'b1) $display("FAIL skip_pass: got %b want 1", pd); else passed++;
  endtask

  task automatic test_mask_garbage();
    int bcyc, dcnt; logic pd;
    clear_modes(); set_fixed_table(); stub_init(); m_garbage1 = 1;
    run_sweep(1'b0, -1, bcyc, dcnt, pd);
    total++; if (err_cnt !== 0 || pass !== 1'b1) $display("FAIL mask_garbage: got cnt=%0d pass=%b want 0/1", err_cnt, pass); else passed++;
  endtask

  task automatic test_saturate();
    int bcyc, dcnt; logic pd;
    logic [ERRW-1:0] ec; logic [IDXW-1:0] ei; logic [1:0] ep; logic [DW-1:0] eg;
    clear_modes(); set_fixed_table(); stub_init(); m_serial = 1;
    run_sweep(1'b0, -1, bcyc, dcnt, pd);
    model(1'b0, ec, ei, ep, eg);
    total++; if (err_cnt !== 3'd7) $display("FAIL sat_err_cnt: got %0d want 7", err_cnt); else passed++;
    total++; if (err_idx !== ei || err_phase !== ep || err_got !== eg)
      $display("FAIL sat_first_err: got %0d/%0d/%h want %0d/%0d/%h", err_idx, err_phase, err_got, ei, ep, eg); else passed++;
  endtask

  task automatic test_reset_mid();
    int bcyc, dcnt; logic pd; bit found = 0; int dones = 0;
    clear_modes(); set_fixed_table(); stub_init();
    wlog_a.delete(); wlog_d.delete();
    start = 1'b1; skip_write = 1'b0;
    @(negedge gb_clk);
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (tbl_idx == 2 && wlog_a.size() == 2) begin found = 1; break; end
      @(negedge gb_clk);
    end
    total++; if (!found) $display("FAIL rstmid_reach_write2: got not reached want reached"); else passed++;
    gb_rst = 1'b1;
    @(negedge gb_clk);
    total++;
    if ({busy, done, pass, err_cnt, err_idx, err_phase, err_got, tbl_idx,
         gb_addr, gb_wdata, gb_wen, gb_rstb} !== '0)
      $display("FAIL rstmid_outputs: got busy=%b idx=%0d addr=%h wen=%b, want all 0", busy, tbl_idx, gb_addr, gb_wen);
    else passed++;
    @(negedge gb_clk);
    gb_rst = 1'b0;
    repeat (20) begin @(negedge gb_clk); if (done || busy) dones++; end
    total++; if (dones !== 0) $display("FAIL rstmid_no_done: got %0d active cycles want 0", dones); else passed++;
    run_sweep(1'b0, -1, bcyc, dcnt, pd);
    total++; if (pd !== 1'b1 || dcnt !== 1) $display("FAIL rstmid_fresh_pass: got pass=%b done=%0d want 1/1", pd, dcnt); else passed++;
  endtask

  task automatic test_back_to_back();
    int bcyc, dcnt; logic pd;
    clear_modes(); set_fixed_table(); stub_init();
    run_sweep(1'b0, 17, bcyc, dcnt, pd);
    total++; if (bcyc !== exp_busy(0) || dcnt !== 1) $display("FAIL b2b_stray_start: got %0d/%0d want %0d/1", bcyc, dcnt, exp_busy(0)); else passed++;
    run_sweep(1'b1, -1, bcyc, dcnt, pd);
    total++; if (bcyc !== exp_busy(1) || dcnt !== 1 || pd !== 1'b1)
      $display("FAIL b2b_second: got %0d/%0d/%b want %0d/1/1", bcyc, dcnt, pd, exp_busy(1)); else passed++;
  endtask

  task automatic test_random();
    int bcyc, dcnt; logic pd; bit skip; bit dup;
    logic [ERRW-1:0] ec; logic [IDXW-1:0] ei; logic [1:0] ep; logic [DW-1:0] eg;
    for (int it = 0; it < 8; it++) begin
      clear_modes();
      for (int i = 0; i < N; i++) begin
        for (int tries = 0; tries < 100; tries++) begin
          t_addr[i] = AW'($urandom_range(0, 63));
          dup = 0;
          for (int j = 0; j < i; j++) if (t_addr[j] == t_addr[i]) dup = 1;
          if (!dup) break;
        end
        t_wval[i] = $urandom;
        t_mask[i] = $urandom;
      end
      for (int i = 0; i < 64; i++) init_val[i] = $urandom;
      stub_load = 1'b1; @(negedge gb_clk); stub_load = 1'b0;
      m_noise = (it % 4) != 0;
      skip = $urandom_range(0, 1);
      run_sweep(skip, -1, bcyc, dcnt, pd);
      model(skip, ec, ei, ep, eg);
      total++; if (err_cnt !== ec || pass !== (ec == 0) || dcnt !== 1)
        $display("FAIL rand%0d_count: got cnt=%0d pass=%b done=%0d want %0d/%b/1", it, err_cnt, pass, dcnt, ec, ec == 0); else passed++;
      total++; if (err_idx !== ei || err_phase !== ep || err_got !== eg)
        $display("FAIL rand%0d_first_err: got %0d/%0d/%h want %0d/%0d/%h", it, err_idx, err_phase, err_got, ei, ep, eg); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_toggle_repeat();
    test_verify_fail();
    test_skip_write();
    test_mask_garbage();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
